dcache_lsu: RTL and testbench
=============================

DCACHE_LSU -- requirements
Module: dcache_lsu

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, word-address width of the data cache (32 words).
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_i  input  1  core access request, sampled only in IDLE.
REQ-005 SHALL have port we_i  input  1  1 = store, 0 = load.
REQ-006 SHALL have port size_i  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-007 SHALL have port unsigned_i  input  1  1 = zero-extend sub-word loads, 0 = sign-extend.
REQ-008 SHALL have port addr_i  input  ADDR_W+2  byte address.
REQ-009 SHALL have port wdata_i  input  32  store data; sub-word data in low bits.
REQ-010 SHALL have port rdata_o  output  32  registered load result.
REQ-011 SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-012 SHALL have port err_o  output  1  misaligned/reserved-size flag, valid with done_o.
REQ-013 SHALL have port busy_o  output  1  high whenever state is not IDLE.
REQ-014 SHALL have ports dc_writeen_o, dc_readen_o (1), dc_addr_o (ADDR_W), dc_dato_o (32) outputs and dc_dato_i (32) input, driving the cache's write strobe, read enable, word address, write data, and receiving its combinational read data.

Function
REQ-015 SHALL implement states IDLE, LOAD, STORE, RMW_RD, RMW_WR, DONE.
REQ-016 In IDLE with req_i=1, SHALL latch we_i, size_i, unsigned_i, addr_i, wdata_i and branch: misaligned/reserved -> DONE with err; load -> LOAD; word store -> STORE; byte/half store -> RMW_RD.
REQ-017 Misaligned SHALL mean: halfword with addr[0]=1, word with addr[1:0]!=00, or size 11; no cache access occurs.
REQ-018 LOAD (1 cycle): dc_readen_o=1, dc_addr_o=addr[ADDR_W+1:2]; extracted, extended lane captured into rdata_o at cycle end; -> DONE.
REQ-019 Byte lanes SHALL be little-endian: addr[1:0]=n selects bits 8n+7:8n; halfword addr[1]=h selects bits 16h+15:16h.
REQ-020 STORE (1 cycle): dc_writeen_o=1, dc_dato_o=latched wdata; -> DONE.
REQ-021 RMW_RD (1 cycle): dc_readen_o=1, old word captured internally; -> RMW_WR.
REQ-022 RMW_WR (1 cycle): dc_writeen_o=1, dc_dato_o = old word with only selected byte/half lane replaced; -> DONE.
REQ-023 DONE (1 cycle): done_o=1, err_o per REQ-017; -> IDLE; req_i ignored in DONE.
REQ-024 Latency from accepting edge N: done_o high in cycle N+1 for errors, N+2 for loads and word stores, N+3 for sub-word stores.
REQ-025 Outside LOAD/RMW_RD dc_readen_o SHALL be 0; outside STORE/RMW_WR dc_writeen_o SHALL be 0; dc_addr_o/dc_dato_o driven from latched values only.
REQ-026 rdata_o SHALL hold its value until the next load completes; stores and errors leave it unchanged.
REQ-027 req_i while busy_o=1 SHALL be ignored with no side effect.

Reset
REQ-028 With rst_ni=0 at a rising edge: state IDLE, rdata_o=0, done_o=0, err_o=0, latched request cleared.
REQ-029 dc_writeen_o and dc_readen_o SHALL be forced 0 combinationally while rst_ni=0, so reset mid-operation (including in STORE or RMW_WR) never writes the cache.
REQ-030 Cache contents are not reset by this block.

Structure
REQ-031 Package dcache_lsu_pkg SHALL hold size encodings, state enumeration and the ADDR_W default.
REQ-032 Sub-module dcache_lsu_align SHALL hold the combinational lane extraction/extension and store merge logic.

Verification
REQ-033 Word store 0xDEADBEEF to addr 0x08, then word load 0x08 -> dc_writeen_o one cycle at dc_addr_o=2; load done_o at N+2, rdata_o=0xDEADBEEF.
REQ-034 Byte store 0x55 to addr 0x09 over word 0xDEADBEEF -> RMW read then write 0xDEAD55EF; done_o at N+3.
REQ-035 Byte load addr 0x0B signed then unsigned from 0xDEAD55EF -> rdata_o 0xFFFFFFDE, then 0x000000DE; halfword load 0x08 signed -> 0x000055EF.
REQ-036 Word load at addr 0x0A and size 11 -> done_o and err_o at N+1, no dc strobes, rdata_o unchanged.
REQ-037 rst_ni=0 during RMW_WR -> dc_writeen_o=0, cache word unchanged, state IDLE, busy_o=0 next cycle.
REQ-038 req_i held high through an operation -> exactly one access per IDLE visit; second request accepted only after DONE.

Source files
------------

// File: rtl/dcache_lsu_pkg.sv
// Shared definitions for the data-cache load/store unit: access sizes,
// controller states and the default cache geometry.
package dcache_lsu_pkg;

    localparam int unsigned ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STORE  = 3'd2,
        S_RMW_RD = 3'd3,
        S_RMW_WR = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    // Reserved size counts as misaligned so it takes the same no-access path.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            SZ_WORD: return (off != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dcache_lsu_align.sv
// Little-endian lane extraction/extension for loads and lane merge for
// sub-word stores; purely combinational.
module dcache_lsu_align
    import dcache_lsu_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_rword,
    input  logic [31:0] i_old,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_ldata,
    output logic [31:0] o_merge
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_off)
            2'd0:    w_byte = i_rword[7:0];
            2'd1:    w_byte = i_rword[15:8];
            2'd2:    w_byte = i_rword[23:16];
            default: w_byte = i_rword[31:24];
        endcase
        w_half = i_off[1] ? i_rword[31:16] : i_rword[15:0];

        o_ldata = i_rword;
        case (i_size)
            SZ_BYTE: o_ldata = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: o_ldata = {{16{~i_unsigned & w_half[15]}}, w_half};
            default: ;
        endcase

        o_merge = i_old;
        case (i_size)
            SZ_BYTE: begin
                case (i_off)
                    2'd0:    o_merge[7:0]   = i_wdata[7:0];
                    2'd1:    o_merge[15:8]  = i_wdata[7:0];
                    2'd2:    o_merge[23:16] = i_wdata[7:0];
                    default: o_merge[31:24] = i_wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (i_off[1]) o_merge[31:16] = i_wdata[15:0];
                else          o_merge[15:0]  = i_wdata[15:0];
            end
            default: o_merge = i_wdata;
        endcase
    end

endmodule

// File: rtl/dcache_lsu.sv
// Load/store unit in front of a single-port word-addressed data cache:
// sub-word loads, read-modify-write sub-word stores, misalignment errors.
module dcache_lsu
    import dcache_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W+1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              done_o,
    output logic              err_o,
    output logic              busy_o,
    output logic              dc_writeen_o,
    output logic              dc_readen_o,
    output logic [ADDR_W-1:0] dc_addr_o,
    output logic [31:0]       dc_dato_o,
    input  logic [31:0]       dc_dato_i
);

    state_e              r_state;
    state_e              w_next;
    logic [1:0]          r_size;
    logic                r_uns;
    logic [ADDR_W+1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_old;
    logic [31:0]         r_rdata;
    logic                r_err;
    logic                w_mis;
    logic                w_rd_en;
    logic                w_wr_en;
    logic [31:0]         w_ldata;
    logic [31:0]         w_merge;

    assign w_mis = misaligned(size_i, addr_i[1:0]);

    // Store direction is not kept in a register: it is implied by the state path.
    always_comb begin
        w_next  = r_state;
        w_rd_en = 1'b0;
        w_wr_en = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_i) begin
                    if (w_mis)               w_next = S_DONE;
                    else if (!we_i)          w_next = S_LOAD;
                    else if (size_i == SZ_WORD) w_next = S_STORE;
                    else                     w_next = S_RMW_RD;
                end
            end
            S_LOAD: begin
                w_rd_en = 1'b1;
                w_next  = S_DONE;
            end
            S_STORE: begin
                w_wr_en = 1'b1;
                w_next  = S_DONE;
            end
            S_RMW_RD: begin
                w_rd_en = 1'b1;
                w_next  = S_RMW_WR;
            end
            S_RMW_WR: begin
                w_wr_en = 1'b1;
                w_next  = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_size  <= '0;
            r_uns   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_old   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && req_i) begin
                r_size  <= size_i;
                r_uns   <= unsigned_i;
                r_addr  <= addr_i;
                r_wdata <= wdata_i;
                r_err   <= w_mis;
            end
            if (r_state == S_LOAD)   r_rdata <= w_ldata;
            if (r_state == S_RMW_RD) r_old   <= dc_dato_i;
        end
    end

    dcache_lsu_align u_align (
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .i_off      (r_addr[1:0]),
        .i_rword    (dc_dato_i),
        .i_old      (r_old),
        .i_wdata    (r_wdata),
        .o_ldata    (w_ldata),
        .o_merge    (w_merge)
    );

    // Strobes are gated by reset directly so a reset mid-write never reaches the cache.
    assign dc_readen_o  = w_rd_en & rst_ni;
    assign dc_writeen_o = w_wr_en & rst_ni;
    assign dc_addr_o    = r_addr[ADDR_W+1:2];
    assign dc_dato_o    = w_merge;

    assign rdata_o = r_rdata;
    assign busy_o  = (r_state != S_IDLE);
    assign done_o  = (r_state == S_DONE);
    assign err_o   = (r_state == S_DONE) & r_err;

endmodule

// File: tb/tb_dcache_lsu.sv
// Directed self-checking bench for dcache_lsu with a behavioural 32-word cache.
module tb_dcache_lsu;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        err;
    logic        busy;
    logic        dc_we;
    logic        dc_re;
    logic [4:0]  dc_addr;
    logic [31:0] dc_wd;
    logic [31:0] dc_rd;

    logic [31:0] mem [32];
    int          n_checks;
    int          n_errors;
    int          rd_cnt;
    int          wr_cnt;
    logic [4:0]  last_waddr;

    dcache_lsu #(.ADDR_W(5)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req),
        .we_i         (we),
        .size_i       (size),
        .unsigned_i   (uns),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .rdata_o      (rdata),
        .done_o       (done),
        .err_o        (err),
        .busy_o       (busy),
        .dc_writeen_o (dc_we),
        .dc_readen_o  (dc_re),
        .dc_addr_o    (dc_addr),
        .dc_dato_o    (dc_wd),
        .dc_dato_i    (dc_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dc_rd = mem[dc_addr];

    always @(posedge clk) begin
        if (dc_we) begin
            mem[dc_addr] <= dc_wd;
            last_waddr   <= dc_addr;
            wr_cnt       <= wr_cnt + 1;
        end
        if (dc_re) rd_cnt <= rd_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // One request; returns cycles to done (1 = first cycle after accept), strobe counts and err.
    task automatic do_op(input logic i_we, input logic [1:0] i_sz, input logic i_un,
                         input logic [6:0] i_a, input logic [31:0] i_wd,
                         output int lat, output int rds, output int wrs, output logic e);
        int rd0;
        int wr0;
        @(negedge clk);
        req = 1'b1; we = i_we; size = i_sz; uns = i_un; addr = i_a; wdata = i_wd;
        rd0 = rd_cnt; wr0 = wr_cnt;
        @(posedge clk); #1;
        req = 1'b0;
        lat = 1;
        while (!done && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done) lat = 99;
        e = err;
        @(negedge clk);
        rds = rd_cnt - rd0;
        wrs = wr_cnt - wr0;
    endtask

    int          lat;
    int          rds;
    int          wrs;
    logic        e;
    logic [31:0] saved;
    int          dones;
    int          first_done;
    int          second_done;

    initial begin
        n_checks = 0; n_errors = 0; rd_cnt = 0; wr_cnt = 0; last_waddr = '0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[3] = 32'h3333_3333;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdata", rdata, 32'h0);
        check("rst_done",  {31'b0, done}, 32'h0);
        check("rst_err",   {31'b0, err},  32'h0);
        check("rst_busy",  {31'b0, busy}, 32'h0);
        check("rst_strb",  {30'b0, dc_we, dc_re}, 32'h0);
        @(negedge clk); rst_n = 1'b1;

        do_op(1'b1, 2'b10, 1'b0, 7'h08, 32'hDEADBEEF, lat, rds, wrs, e);
        check("sw_lat",   lat, 2);
        check("sw_wrs",   wrs, 1);
        check("sw_rds",   rds, 0);
        check("sw_waddr", {27'b0, last_waddr}, 32'd2);
        check("sw_mem",   mem[2], 32'hDEADBEEF);
        check("sw_rdata", rdata, 32'h0);

        do_op(1'b0, 2'b10, 1'b0, 7'h08, 32'h0, lat, rds, wrs, e);
        check("lw_lat",   lat, 2);
        check("lw_rds",   rds, 1);
        check("lw_rdata", rdata, 32'hDEADBEEF);

        do_op(1'b1, 2'b00, 1'b0, 7'h09, 32'h0000_0055, lat, rds, wrs, e);
        check("sb_lat", lat, 3);
        check("sb_rds", rds, 1);
        check("sb_wrs", wrs, 1);
        check("sb_mem", mem[2], 32'hDEAD55EF);

        do_op(1'b0, 2'b00, 1'b0, 7'h0B, 32'h0, lat, rds, wrs, e);
        check("lb_s_lat",   lat, 2);
        check("lb_s_rdata", rdata, 32'hFFFFFFDE);
        do_op(1'b0, 2'b00, 1'b1, 7'h0B, 32'h0, lat, rds, wrs, e);
        check("lbu_rdata",  rdata, 32'h000000DE);
        do_op(1'b0, 2'b01, 1'b0, 7'h08, 32'h0, lat, rds, wrs, e);
        check("lh_lo_rdata", rdata, 32'h000055EF);
        do_op(1'b0, 2'b01, 1'b0, 7'h0A, 32'h0, lat, rds, wrs, e);
        check("lh_hi_rdata", rdata, 32'hFFFFDEAD);
        do_op(1'b0, 2'b01, 1'b1, 7'h0A, 32'h0, lat, rds, wrs, e);
        check("lhu_rdata", rdata, 32'h0000DEAD);

        do_op(1'b1, 2'b01, 1'b0, 7'h0A, 32'hFFFF_1234, lat, rds, wrs, e);
        check("sh_lat", lat, 3);
        check("sh_mem", mem[2], 32'h123455EF);
        check("sh_rdata_held", rdata, 32'h0000DEAD);

        saved = rdata;
        do_op(1'b0, 2'b10, 1'b0, 7'h0A, 32'h0, lat, rds, wrs, e);
        check("mis_w_lat",  lat, 1);
        check("mis_w_err",  {31'b0, e}, 32'd1);
        check("mis_w_strb", rds + wrs, 0);
        check("mis_w_rdata", rdata, saved);
        do_op(1'b1, 2'b11, 1'b0, 7'h08, 32'hAAAA_AAAA, lat, rds, wrs, e);
        check("rsvd_lat",  lat, 1);
        check("rsvd_err",  {31'b0, e}, 32'd1);
        check("rsvd_strb", rds + wrs, 0);
        check("rsvd_mem",  mem[2], 32'h123455EF);
        do_op(1'b0, 2'b01, 1'b0, 7'h09, 32'h0, lat, rds, wrs, e);
        check("mis_h_err", {31'b0, e}, 32'd1);
        do_op(1'b0, 2'b10, 1'b0, 7'h0C, 32'h0, lat, rds, wrs, e);
        check("ok_err",   {31'b0, e}, 32'd0);
        check("ok_rdata", rdata, 32'h33333333);

        // Request held high: one access per IDLE visit, next accept only after DONE.
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'b10; uns = 1'b0; addr = 7'h08;
        rds = rd_cnt; dones = 0; first_done = 0; second_done = 0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            if (done) begin
                dones++;
                if (dones == 1) first_done = c;
                else second_done = c;
            end
        end
        @(negedge clk);
        req = 1'b0;
        check("hold_dones",  dones, 2);
        check("hold_first",  first_done, 2);
        check("hold_second", second_done, 5);
        check("hold_reads",  rd_cnt - rds, 2);
        repeat (3) @(negedge clk);
        check("hold_idle", {31'b0, busy}, 32'd0);

        // Reset while in RMW_WR must suppress the write.
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b00; uns = 1'b0; addr = 7'h08; wdata = 32'h0000_00AA;
        wrs = wr_cnt;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        check("rmw_wr_strobe_pre", {31'b0, dc_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_we", {31'b0, dc_we}, 32'd0);
        @(posedge clk); #1;
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_mem",  mem[2], 32'h123455EF);
        check("rst_mid_wrs",  wr_cnt - wrs, 0);
        check("rst_mid_rdata", rdata, 32'h0);
        @(negedge clk); rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
